game_cmd_decoder: RTL

- Upstream feeder of the game-state register.
- Parses a byte stream from the UART receiver into validated 3-byte command frames.
- Emits a one-cycle `en` strobe plus a 2-bit `func` code that the game-state block consumes directly.
- Rejects malformed frames and counts them for debug LEDs.

---
 rtl/game_cmd_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/game_cmd_decoder.sv
// UART byte-stream command decoder: validates SYNC/OPCODE/~OPCODE frames into en/func strobes.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module game_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 en,
  output logic [1:0]           func,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StGotSync, StGotOp} state_e;

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic                 en_q, en_d;
  logic [1:0]           func_q, func_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 reject;
  logic                 opcode_ok;
  logic                 timeout;

  assign opcode_ok = (opcode_q[7:2] == 6'd0) && (opcode_q[1:0] != 2'b00);

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = (state_q != StIdle) && !rx_valid &&
                   (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    if (rx_valid || (state_q == StIdle) || timeout) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    en_d     = 1'b0;
    func_d   = func_q;
    reject   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StGotSync;
        end
      end
      StGotSync: begin
        if (rx_valid) begin
          opcode_d = rx_data;
          state_d  = StGotOp;
        end else if (timeout) begin
          reject  = 1'b1;
          state_d = StIdle;
        end
      end
      StGotOp: begin
        if (rx_valid) begin
          if ((rx_data == ~opcode_q) && opcode_ok) begin
            en_d    = 1'b1;
            func_d  = opcode_q[1:0];
            state_d = StIdle;
          end else begin
            reject  = 1'b1;
            // A bad CHK that looks like a sync byte starts the next frame.
            state_d = (rx_data == SYNC_BYTE) ? StGotSync : StIdle;
          end
        end else if (timeout) begin
          reject  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frame_err_d = reject;
    err_cnt_d   = err_cnt_q;
    if (reject && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opcode_q    <= 8'h00;
      en_q        <= 1'b0;
      func_q      <= 2'b00;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      en_q        <= en_d;
      func_q      <= func_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign en        = en_q;
  assign func      = func_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != StIdle);

endmodule
